ram_initiator: RTL
==================

Name: ram_initiator

Overview:
- Initiator/controller that drives the chip-select/read/write port of the team's synchronous_ram (the responder).
- Takes single-beat write commands and 1..4-beat incrementing read bursts from a client over a valid/ready request channel.
- Sequences the RAM strobes, waits out the RAM read latency, and returns read data over a valid/ready response channel with backpressure.
- Sits between any client logic (test sequencer, DMA, CPU shim) and synchronous_ram.

Parameters:
- ADDR_W, 2, RAM address width; the address space wraps at 2^ADDR_W.
- DATA_W, 8, RAM data width.
- LEN_W, 2, burst length field width; a burst is req_len+1 beats.
- RD_LATENCY, 1, cycles from the end of a RAM read-strobe cycle until ram_dout is valid (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  client command valid.
- req_ready  out  1  controller can accept a command (high only in IDLE).
- req_write  in  1  1 = write, 0 = read burst.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  read beats minus 1; ignored for writes.
- req_wdata  in  DATA_W  write data.
- wr_done  out  1  one-cycle pulse when a write strobe has been issued.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  client accepts the response.
- rsp_data  out  DATA_W  read data.
- rsp_last  out  1  final beat of the burst; qualified by rsp_valid.
- busy  out  1  high in any state other than IDLE.
- ram_addr  out  ADDR_W  connects to RAM addr.
- ram_cs  out  1  connects to RAM CS.
- ram_rd  out  1  connects to RAM RD.
- ram_we  out  1  connects to RAM WE.
- ram_din  out  DATA_W  connects to RAM dataIn.
- ram_dout  in  DATA_W  connects to RAM dataOut.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - Reset outputs: req_ready=1 (IDLE), and every other output is 0: ram_cs, ram_rd, ram_we, ram_addr, ram_din, rsp_valid, rsp_data, rsp_last, wr_done, busy.
- States: IDLE, WR, RD, WAIT, RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, latch addr/len/wdata/write and clear the beat counter.
  - Next state is WR if req_write=1, otherwise RD.
- WR (one cycle):
  - ram_cs=1, ram_we=1, ram_rd=0, ram_addr=latched address, ram_din=wdata.
  - wr_done=1 in the following cycle, together with the return to IDLE.
- RD (one cycle):
  - ram_cs=1, ram_rd=1, ram_we=0, ram_addr=current beat address.
  - Next state is WAIT.
- WAIT:
  - Lasts RD_LATENCY cycles; ram_cs/ram_rd/ram_we=0.
  - At the edge ending the final WAIT cycle, capture ram_dout into rsp_data. Next state is RESP.
- RESP:
  - rsp_valid=1; rsp_last=1 when beat==len.
  - rsp_data and rsp_last are held stable until the rsp_valid && rsp_ready edge.
  - On acceptance: if this was the last beat, go to IDLE. Otherwise increment beat, advance the address by +1 mod 2^ADDR_W (wraps, e.g. 3 -> 0), and go to RD.
- Timing:
  - Read: the request is accepted at edge E0, the strobe is in cycle 1, and rsp_valid first rises in cycle 2+RD_LATENCY (cycle 3 at default).
  - Each further beat after acceptance costs 2+RD_LATENCY cycles.
  - Write: strobe in cycle 1; wr_done and req_ready in cycle 2.
- Invariants:
  - ram_rd and ram_we are never high together.
  - No strobe is issued outside WR/RD.
  - The RAM is never strobed while a response is pending (no new RAM access is issued while rsp_valid=1).
- Boundaries:
  - req_valid while busy is ignored; it is not queued.
  - rsp_ready held low stalls indefinitely with data stable.
  - A burst starting at the top address wraps.
  - rsp_ready high before rsp_valid has no effect.
  - Reset mid-burst or mid-wait: the controller returns to IDLE at that edge; pending data is dropped, no further strobes are issued, and outputs take their reset values.

Decomposition:
- Shared package ram_if_pkg:
  - state enum {IDLE, WR, RD, WAIT, RESP};
  - default ADDR_W/DATA_W/LEN_W constants;
  - RD_LATENCY default.
- No sub-module required. The latency counter and beat/address counter stay inline in the FSM.

Test Plan:
- Reset held 2 cycles -> all outputs 0, req_ready=1, busy=0; no RAM strobe while reset is high.
- Write addr=1, data=0xCC -> exactly one cycle of ram_cs=1/ram_we=1 with ram_addr=1, ram_din=0xCC; wr_done pulses one cycle later; RAM model location 1 = 0xCC.
- Read addr=1, len=0 after the above -> single ram_rd strobe; rsp_valid=1 with rsp_data=0xCC and rsp_last=1 in cycle 3 after acceptance; then back to IDLE.
- Preload the RAM with {0:0x11, 1:0x22, 2:0xF0, 3:0x33}; read addr=2, len=3 -> strobed addresses are 2,3,0,1; responses are 0xF0, 0x33, 0x11, 0x22; rsp_last only on the 4th beat.
- During a burst hold rsp_ready=0 for 5 cycles, and pulse req_valid while busy -> rsp_data stable, no RAM strobe, req_ready=0, the extra command is ignored; the burst resumes when rsp_ready=1.
- Assert reset in the WAIT state of beat 2 of a 4-beat burst -> IDLE on the next cycle, all outputs 0, no further ram_cs; a subsequent read of addr=0 completes normally.

Source files
------------

// File: rtl/ram_if_pkg.sv
// Shared types and default sizes for the synchronous_ram initiator port.
// The state enum is shared so client-side logic can decode the controller state.
package ram_if_pkg;

  localparam int ADDR_W_DEF     = 2;
  localparam int DATA_W_DEF     = 8;
  localparam int LEN_W_DEF      = 2;
  localparam int RD_LATENCY_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/ram_initiator.sv
// Initiator for synchronous_ram: single-beat writes and 1..4 beat incrementing
// read bursts, with a valid/ready response channel that tolerates backpressure.
module ram_initiator
  import ram_if_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              wr_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_rd,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  // Wait-counter value on the final WAIT cycle; RD_LATENCY is limited to 1..3.
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat;
  logic [1:0]        lat_cnt;

  // Every output is driven straight from a register, so each strobe and
  // handshake signal appears in the cycle after the edge that decides it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      beat      <= '0;
      lat_cnt   <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      wr_done   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      ram_addr  <= '0;
      ram_cs    <= 1'b0;
      ram_rd    <= 1'b0;
      ram_we    <= 1'b0;
      ram_din   <= '0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            len_q     <= req_len;
            beat      <= '0;
            ram_addr  <= req_addr;
            ram_cs    <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_write) begin
              ram_we  <= 1'b1;
              ram_din <= req_wdata;
              state   <= WR;
            end else begin
              ram_rd  <= 1'b1;
              state   <= RD;
            end
          end
        end

        WR: begin
          ram_cs    <= 1'b0;
          ram_we    <= 1'b0;
          wr_done   <= 1'b1;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        RD: begin
          ram_cs  <= 1'b0;
          ram_rd  <= 1'b0;
          lat_cnt <= '0;
          state   <= WAIT;
        end

        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rsp_data  <= ram_dout;
            rsp_valid <= 1'b1;
            rsp_last  <= (beat == len_q);
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        // The next beat is strobed only after the current one is accepted,
        // so the RAM stays idle for as long as the client stalls.
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (rsp_last) begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              beat     <= beat + 1'b1;
              addr_q   <= addr_q + 1'b1;
              ram_addr <= addr_q + 1'b1;
              ram_cs   <= 1'b1;
              ram_rd   <= 1'b1;
              state    <= RD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
